// File: rtl/prim_executor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prim_executor_pkg
//  Brief    : Opcodes, FSM state encodings, lane masks and lane-select helper
//             shared by the primitive executor and its lane helper.
//  Revision : 1.0 - initial release
// ============================================================================
package prim_executor_pkg;

    localparam int DATA_W = 32;
    localparam int HALF_W = 16;

    typedef logic [5:0] opcode_t;

    // Primitive opcodes (inst[63:58])
    localparam opcode_t c_op_nop       = 6'd0;
    localparam opcode_t c_op_add       = 6'd2;
    localparam opcode_t c_op_copy      = 6'd3;
    localparam opcode_t c_op_set_field = 6'd4;
    localparam opcode_t c_op_set_port  = 6'd5;

    // Executor states
    localparam logic [3:0] c_st_idle = 4'd0;
    localparam logic [3:0] c_st_f1   = 4'd1;
    localparam logic [3:0] c_st_f2   = 4'd2;
    localparam logic [3:0] c_st_f3   = 4'd3;
    localparam logic [3:0] c_st_ex   = 4'd4;
    localparam logic [3:0] c_st_r1   = 4'd5;
    localparam logic [3:0] c_st_r2   = 4'd6;
    localparam logic [3:0] c_st_wr   = 4'd7;
    localparam logic [3:0] c_st_done = 4'd8;

    // Byte-lane masks for the two halfword lanes of a word
    localparam logic [3:0] c_sel_lo = 4'b0011;
    localparam logic [3:0] c_sel_hi = 4'b1100;

    function automatic logic [3:0] lane_sel(input logic i_hi);
        return i_hi ? c_sel_hi : c_sel_lo;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prim_executor_hw_lane.sv
`default_nettype none
// ============================================================================
//  Module   : hw_lane
//  Brief    : Halfword lane helper. Extracts the halfword at lane i_hi from
//             i_word, and places i_half into the same lane of an otherwise
//             zero write word together with the matching byte selects.
//  Revision : 1.0 - initial release
// ============================================================================
module hw_lane
    import prim_executor_pkg::*;
(
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_hi,
    input  logic [HALF_W-1:0] i_half,
    output logic [HALF_W-1:0] o_half,
    output logic [DATA_W-1:0] o_word,
    output logic [3:0]        o_sel
);

    // Kept as independent assigns: o_half feeds back into i_half at the top
    // level, so extract and build must not share a process.
    assign o_half = i_hi ? i_word[31:16] : i_word[15:0];
    assign o_word = i_hi ? {i_half, 16'h0000} : {16'h0000, i_half};
    assign o_sel  = lane_sel(i_hi);

endmodule
`default_nettype wire

// File: rtl/prim_executor.sv
`default_nettype none
// ============================================================================
//  Module   : prim_executor
//  Brief    : Fetches a list of 64-bit primitives from SRAM and executes them
//             against the packet buffer (set/add/copy 16-bit fields, set the
//             egress port), then reports done/error until start drops.
//  Revision : 1.0 - initial release
// ============================================================================
module prim_executor
    import prim_executor_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int PORT_W    = 8,     // must not exceed 16
    parameter int MAX_INSTS = 16
) (
    input  logic              clk,
    input  logic              rst,            // asynchronous, active-low
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] pkt_base_i,
    output logic              sram_ce_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [3:0]        sram_sel_o,
    output logic [31:0]       sram_data_o,
    input  logic [31:0]       sram_data_i,
    output logic              busy_o,
    output logic              exec_done_o,
    output logic              exec_err_o,
    output logic [PORT_W-1:0] egress_port_o,
    output logic              port_valid_o
);

    localparam int CNT_W = $clog2(MAX_INSTS + 1);

    logic [3:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pkt_base;
    logic [CNT_W-1:0]  r_count;
    opcode_t           r_op;
    logic [15:1]       r_dst;       // offset bit 0 is ignored, so not stored
    logic [15:1]       r_src;
    logic [15:0]       r_imm;
    logic              r_ce;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_sel;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [PORT_W-1:0] r_port;
    logic              r_port_valid;

    logic [ADDR_W-1:0] w_dst_addr;
    logic [ADDR_W-1:0] w_src_addr;
    logic [31:0]       w_lane_in;
    logic [15:0]       w_lane_half;
    logic [15:0]       w_new_half;
    logic [31:0]       w_lane_word;
    logic [3:0]        w_lane_sel;
    logic              w_at_limit;

    assign w_dst_addr = r_pkt_base + ADDR_W'({r_dst[15:2], 2'b00});
    assign w_src_addr = r_pkt_base + ADDR_W'({r_src[15:2], 2'b00});
    assign w_at_limit = (r_count == CNT_W'(MAX_INSTS));

    // A copy between opposite lanes swaps the read word first, so a single
    // lane helper indexed by the destination lane serves every primitive.
    assign w_lane_in = ((r_op == c_op_copy) && (r_src[1] != r_dst[1]))
                     ? {sram_data_i[15:0], sram_data_i[31:16]}
                     : sram_data_i;

    // New destination halfword: sum for ADD, source field for COPY, imm otherwise
    assign w_new_half = (r_op == c_op_add)  ? (w_lane_half + r_imm) :
                        (r_op == c_op_copy) ? w_lane_half : r_imm;

    hw_lane u_lane (
        .i_word (w_lane_in),
        .i_hi   (r_dst[1]),
        .i_half (w_new_half),
        .o_half (w_lane_half),
        .o_word (w_lane_word),
        .o_sel  (w_lane_sel)
    );

    // Fetch / execute sequencer; all SRAM strobes are registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_st_idle;
            r_pc         <= '0;
            r_pkt_base   <= '0;
            r_count      <= '0;
            r_op         <= '0;
            r_dst        <= '0;
            r_src        <= '0;
            r_imm        <= '0;
            r_ce         <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_sel        <= '0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
            r_port       <= '0;
            r_port_valid <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start_i) begin
                        r_pkt_base   <= pkt_base_i;
                        r_addr       <= start_addr_i;
                        r_ce         <= 1'b1;
                        r_pc         <= start_addr_i + ADDR_W'(8);
                        r_count      <= '0;
                        r_port_valid <= 1'b0;
                        r_state      <= c_st_f1;
                    end
                end
                c_st_f1: begin
                    r_addr  <= r_addr + ADDR_W'(4);
                    r_state <= c_st_f2;
                end
                c_st_f2: begin
                    r_op    <= sram_data_i[31:26];
                    r_dst   <= sram_data_i[15:1];
                    r_state <= c_st_f3;
                end
                c_st_f3: begin
                    r_src   <= sram_data_i[31:17];
                    r_imm   <= sram_data_i[15:0];
                    r_count <= r_count + CNT_W'(1);
                    r_state <= c_st_ex;
                end
                c_st_ex: begin
                    case (r_op)
                        c_op_set_port: begin
                            r_port       <= r_imm[PORT_W-1:0];
                            r_port_valid <= 1'b1;
                            if (w_at_limit) begin
                                r_ce    <= 1'b0;
                                r_err   <= 1'b1;
                                r_state <= c_st_done;
                            end else begin
                                r_addr  <= r_pc;
                                r_pc    <= r_pc + ADDR_W'(8);
                                r_state <= c_st_f1;
                            end
                        end
                        c_op_set_field: begin
                            r_addr  <= w_dst_addr;
                            r_we    <= 1'b1;
                            r_sel   <= w_lane_sel;
                            r_wdata <= w_lane_word;
                            r_state <= c_st_wr;
                        end
                        c_op_add: begin
                            r_addr  <= w_dst_addr;
                            r_state <= c_st_r1;
                        end
                        c_op_copy: begin
                            r_addr  <= w_src_addr;
                            r_state <= c_st_r1;
                        end
                        c_op_nop: begin
                            r_ce    <= 1'b0;
                            r_state <= c_st_done;
                        end
                        default: begin
                            r_ce    <= 1'b0;
                            r_err   <= 1'b1;
                            r_state <= c_st_done;
                        end
                    endcase
                end
                c_st_r1: begin
                    r_state <= c_st_r2;
                end
                c_st_r2: begin
                    r_addr  <= w_dst_addr;
                    r_we    <= 1'b1;
                    r_sel   <= w_lane_sel;
                    r_wdata <= w_lane_word;
                    r_state <= c_st_wr;
                end
                c_st_wr: begin
                    r_we    <= 1'b0;
                    r_sel   <= '0;
                    r_wdata <= '0;
                    if (w_at_limit) begin
                        r_ce    <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= c_st_done;
                    end else begin
                        r_addr  <= r_pc;
                        r_pc    <= r_pc + ADDR_W'(8);
                        r_state <= c_st_f1;
                    end
                end
                c_st_done: begin
                    if (!start_i) begin
                        r_err   <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_ce    <= 1'b0;
                    r_we    <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign sram_ce_o     = r_ce;
    assign sram_we_o     = r_we;
    assign sram_addr_o   = r_addr;
    assign sram_sel_o    = r_sel;
    assign sram_data_o   = r_wdata;
    assign busy_o        = (r_state != c_st_idle);
    assign exec_done_o   = (r_state == c_st_done);
    assign exec_err_o    = r_err;
    assign egress_port_o = r_port;
    assign port_valid_o  = r_port_valid;

endmodule
`default_nettype wire

// File: tb/tb_prim_executor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prim_executor
//  Brief    : Directed self-checking bench for prim_executor with a small
//             registered-read SRAM model and a write log.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prim_executor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] start_addr_i;
    logic [31:0] pkt_base_i;
    logic        sram_ce_o;
    logic        sram_we_o;
    logic [31:0] sram_addr_o;
    logic [3:0]  sram_sel_o;
    logic [31:0] sram_data_o;
    logic [31:0] sram_data_i;
    logic        busy_o;
    logic        exec_done_o;
    logic        exec_err_o;
    logic [7:0]  egress_port_o;
    logic        port_valid_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prim_executor #(.ADDR_W(32), .PORT_W(8), .MAX_INSTS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .start_addr_i (start_addr_i),
        .pkt_base_i   (pkt_base_i),
        .sram_ce_o    (sram_ce_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_sel_o   (sram_sel_o),
        .sram_data_o  (sram_data_o),
        .sram_data_i  (sram_data_i),
        .busy_o       (busy_o),
        .exec_done_o  (exec_done_o),
        .exec_err_o   (exec_err_o),
        .egress_port_o(egress_port_o),
        .port_valid_o (port_valid_o)
    );

    // SRAM model: registered read, byte-lane writes, write log, fetch watch
    logic [31:0] mem [0:4095];
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        log_clr = 1'b0;
    logic [31:0] watch_addr = 32'hFFFF_FFFF;
    int          wr_n = 0;
    int          watch_hits = 0;
    logic [31:0] wl_addr [0:7];
    logic [31:0] wl_data [0:7];
    logic [3:0]  wl_sel  [0:7];

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr[13:2]] <= ld_data;
        if (log_clr) begin
            wr_n       <= 0;
            watch_hits <= 0;
        end else if (sram_ce_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_sel_o[b]) mem[sram_addr_o[13:2]][8*b +: 8] <= sram_data_o[8*b +: 8];
                if (wr_n < 8) begin
                    wl_addr[wr_n] <= sram_addr_o;
                    wl_data[wr_n] <= sram_data_o;
                    wl_sel[wr_n]  <= sram_sel_o;
                end
                wr_n <= wr_n + 1;
            end else if (sram_addr_o == watch_addr) begin
                watch_hits <= watch_hits + 1;
            end
        end
        if (sram_ce_o) sram_data_i <= mem[sram_addr_o[13:2]];
    end

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic load_inst(input logic [31:0] a, input logic [31:0] hi, input logic [31:0] lo);
        load(a, hi);
        load(a + 32'd4, lo);
    endtask

    task automatic clear_log();
        @(negedge clk); log_clr = 1'b1;
        @(negedge clk); log_clr = 1'b0;
    endtask

    // Raise start and count cycles until done (0 if the budget runs out).
    // pkt_base_i is disturbed after the start edge: it must already be latched.
    task automatic run_to_done(input logic [31:0] sa, input logic [31:0] pb, output int cyc);
        @(negedge clk);
        start_addr_i = sa; pkt_base_i = pb; start_i = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) begin pkt_base_i = 32'h0000_3000; start_addr_i = 32'h0000_0F00; end
            if (exec_done_o) begin cyc = i; break; end
        end
    endtask

    task automatic release_start();
        start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; start_i = 1'b0; start_addr_i = '0; pkt_base_i = '0;
        repeat (3) @(negedge clk);
        if ({sram_ce_o, sram_we_o, busy_o, exec_done_o, exec_err_o, port_valid_o} !== 6'b0) begin
            $display("FAIL reset_flags: got %b want 000000",
                     {sram_ce_o, sram_we_o, busy_o, exec_done_o, exec_err_o, port_valid_o});
            n_fail++;
        end
        n_tests++;
        if ({sram_addr_o, sram_sel_o, sram_data_o, egress_port_o} !== 76'h0) begin
            $display("FAIL reset_buses: got addr %h sel %b data %h port %h want 0",
                     sram_addr_o, sram_sel_o, sram_data_o, egress_port_o);
            n_fail++;
        end
        n_tests++;
        rst = 1'b1;
        @(negedge clk);
        if (busy_o !== 1'b0) begin
            $display("FAIL reset_idle_busy: got %b want 0", busy_o); n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_nop();
        int cyc;
        load_inst(32'h0100, 32'h0000_0000, 32'h0000_0000);
        clear_log();
        run_to_done(32'h0100, 32'h1000, cyc);
        if (cyc !== 5) begin $display("FAIL nop_latency: got %0d want 5", cyc); n_fail++; end
        n_tests++;
        if ({busy_o, exec_err_o, sram_ce_o} !== 3'b100) begin
            $display("FAIL nop_status: busy/err/ce got %b want 100", {busy_o, exec_err_o, sram_ce_o});
            n_fail++;
        end
        n_tests++;
        release_start();
        if ({busy_o, exec_done_o} !== 2'b00 || wr_n !== 0) begin
            $display("FAIL nop_return: busy/done got %b writes %0d want 00 / 0", {busy_o, exec_done_o}, wr_n);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_set_field();
        int cyc;
        load_inst(32'h0200, 32'h1000_000C, 32'h0000_0800);
        load_inst(32'h0208, 32'h0000_0000, 32'h0000_0000);
        clear_log();
        run_to_done(32'h0200, 32'h1000, cyc);
        if (cyc !== 10) begin $display("FAIL setf_latency: got %0d want 10", cyc); n_fail++; end
        n_tests++;
        if (wr_n !== 1 || wl_addr[0] !== 32'h100C || wl_sel[0] !== 4'b0011 || wl_data[0] !== 32'h0000_0800) begin
            $display("FAIL setf_write: got n=%0d addr %h sel %b data %h want 1 100c 0011 00000800",
                     wr_n, wl_addr[0], wl_sel[0], wl_data[0]);
            n_fail++;
        end
        n_tests++;
        if (exec_err_o !== 1'b0) begin $display("FAIL setf_err: got %b want 0", exec_err_o); n_fail++; end
        n_tests++;
        release_start();
    endtask

    task automatic test_add();
        int cyc;
        load(32'h100C, 32'hFFFF_1234);
        load_inst(32'h0300, 32'h0800_000E, 32'h0000_0001);
        load_inst(32'h0308, 32'h0800_000C, 32'h0000_0010);
        load_inst(32'h0310, 32'h0000_0000, 32'h0000_0000);
        clear_log();
        run_to_done(32'h0300, 32'h1000, cyc);
        if (cyc !== 19) begin $display("FAIL add_latency: got %0d want 19", cyc); n_fail++; end
        n_tests++;
        if (wr_n !== 2 || wl_addr[0] !== 32'h100C || wl_sel[0] !== 4'b1100 || wl_data[0] !== 32'h0000_0000) begin
            $display("FAIL add_wrap: got n=%0d addr %h sel %b data %h want 2 100c 1100 00000000",
                     wr_n, wl_addr[0], wl_sel[0], wl_data[0]);
            n_fail++;
        end
        n_tests++;
        if (wl_addr[1] !== 32'h100C || wl_sel[1] !== 4'b0011 || wl_data[1] !== 32'h0000_1244) begin
            $display("FAIL add_lo: got addr %h sel %b data %h want 100c 0011 00001244",
                     wl_addr[1], wl_sel[1], wl_data[1]);
            n_fail++;
        end
        n_tests++;
        release_start();
    endtask

    task automatic test_copy();
        int cyc;
        load(32'h1000, 32'hABCD_0000);
        load_inst(32'h0400, 32'h0C00_0004, 32'h0002_0000);
        load_inst(32'h0408, 32'h0C00_0002, 32'h0002_0000);
        load_inst(32'h0410, 32'h0000_0000, 32'h0000_0000);
        clear_log();
        run_to_done(32'h0400, 32'h1000, cyc);
        if (cyc !== 19 || exec_err_o !== 1'b0) begin
            $display("FAIL copy_run: got cycles %0d err %b want 19 0", cyc, exec_err_o); n_fail++;
        end
        n_tests++;
        if (wr_n !== 2 || wl_addr[0] !== 32'h1004 || wl_sel[0] !== 4'b0011 || wl_data[0] !== 32'h0000_ABCD) begin
            $display("FAIL copy_cross: got n=%0d addr %h sel %b data %h want 2 1004 0011 0000abcd",
                     wr_n, wl_addr[0], wl_sel[0], wl_data[0]);
            n_fail++;
        end
        n_tests++;
        if (wl_addr[1] !== 32'h1000 || wl_sel[1] !== 4'b1100 || wl_data[1] !== 32'hABCD_0000) begin
            $display("FAIL copy_self: got addr %h sel %b data %h want 1000 1100 abcd0000",
                     wl_addr[1], wl_sel[1], wl_data[1]);
            n_fail++;
        end
        n_tests++;
        release_start();
    endtask

    task automatic test_port_bad_op();
        int cyc;
        load_inst(32'h0500, 32'h1400_0000, 32'h0000_0107);
        load_inst(32'h0508, 32'hFC00_0000, 32'h0000_0000);
        clear_log();
        run_to_done(32'h0500, 32'h1000, cyc);
        if (cyc !== 9) begin $display("FAIL badop_latency: got %0d want 9", cyc); n_fail++; end
        n_tests++;
        if (egress_port_o !== 8'h07 || port_valid_o !== 1'b1) begin
            $display("FAIL port_value: got %h valid %b want 07 1", egress_port_o, port_valid_o); n_fail++;
        end
        n_tests++;
        if (exec_err_o !== 1'b1 || wr_n !== 0) begin
            $display("FAIL badop_err: got err %b writes %0d want 1 0", exec_err_o, wr_n); n_fail++;
        end
        n_tests++;
        release_start();
        if (exec_err_o !== 1'b0) begin $display("FAIL badop_err_clear: got %b want 0", exec_err_o); n_fail++; end
        n_tests++;
    endtask

    task automatic test_max_insts();
        int cyc;
        for (int i = 0; i < 16; i++)
            load_inst(32'h0600 + 32'(i * 8), 32'h1400_0000, 32'(i + 1));
        load_inst(32'h0680, 32'h0000_0000, 32'h0000_0000);
        watch_addr = 32'h0680;
        clear_log();
        run_to_done(32'h0600, 32'h1000, cyc);
        if (cyc !== 65) begin $display("FAIL max_latency: got %0d want 65", cyc); n_fail++; end
        n_tests++;
        if (exec_err_o !== 1'b1 || egress_port_o !== 8'h10) begin
            $display("FAIL max_err: got err %b port %h want 1 10", exec_err_o, egress_port_o); n_fail++;
        end
        n_tests++;
        if (watch_hits !== 0) begin $display("FAIL max_no_17th_fetch: got %0d want 0", watch_hits); n_fail++; end
        n_tests++;
        release_start();
        watch_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_back_to_back();
        int cyc;
        clear_log();
        run_to_done(32'h0100, 32'h1000, cyc);
        if (cyc !== 5 || port_valid_o !== 1'b0 || egress_port_o !== 8'h10) begin
            $display("FAIL b2b_port_valid_clear: got cycles %0d valid %b port %h want 5 0 10",
                     cyc, port_valid_o, egress_port_o);
            n_fail++;
        end
        n_tests++;
        release_start();
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        load(32'h100C, 32'hFFFF_1234);
        load_inst(32'h0700, 32'h0800_000E, 32'h0000_0001);
        load_inst(32'h0708, 32'h0000_0000, 32'h0000_0000);
        clear_log();
        @(negedge clk);
        start_addr_i = 32'h0700; pkt_base_i = 32'h1000; start_i = 1'b1;
        repeat (6) @(negedge clk);   // now in R2 of the ADD
        rst = 1'b0;
        #1;
        if ({sram_ce_o, sram_we_o, busy_o, exec_done_o, exec_err_o, port_valid_o} !== 6'b0 ||
            sram_addr_o !== 32'h0 || sram_sel_o !== 4'h0 || sram_data_o !== 32'h0) begin
            $display("FAIL rst_mid_outputs: flags %b addr %h sel %b data %h want all 0",
                     {sram_ce_o, sram_we_o, busy_o, exec_done_o, exec_err_o, port_valid_o},
                     sram_addr_o, sram_sel_o, sram_data_o);
            n_fail++;
        end
        n_tests++;
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if (wr_n !== 0) begin $display("FAIL rst_mid_no_write: got %0d want 0", wr_n); n_fail++; end
        n_tests++;
        run_to_done(32'h0200, 32'h1000, cyc);
        if (cyc !== 10 || wr_n !== 1 || wl_addr[0] !== 32'h100C || wl_data[0] !== 32'h0000_0800) begin
            $display("FAIL rst_rerun: got cycles %0d n=%0d addr %h data %h want 10 1 100c 00000800",
                     cyc, wr_n, wl_addr[0], wl_data[0]);
            n_fail++;
        end
        n_tests++;
        repeat (4) @(negedge clk);
        if (exec_done_o !== 1'b1 || busy_o !== 1'b1) begin
            $display("FAIL done_hold: got done %b busy %b want 1 1", exec_done_o, busy_o); n_fail++;
        end
        n_tests++;
        release_start();
        if ({exec_done_o, exec_err_o, busy_o} !== 3'b000) begin
            $display("FAIL done_release: got %b want 000", {exec_done_o, exec_err_o, busy_o}); n_fail++;
        end
        n_tests++;
    endtask

    initial begin
        test_reset();
        test_nop();
        test_set_field();
        test_add();
        test_copy();
        test_port_bad_op();
        test_max_insts();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/prim_executor.md
# prim_executor

Parametrised primitive executor for the match-action stage. After a table hit it fetches a 64-bit primitive list from SRAM and runs the primitives in order against the packet buffer in the same SRAM: set, add and copy 16-bit fields, and set the egress port. It then signals done and holds the result until the requester drops `start_i`. It adds three things over the previous executor: parametrised address/port widths, working field primitives, and a bounded instruction count with error reporting.

## Interface
Parameters:
- `ADDR_W`, 32, SRAM byte-address width.
- `PORT_W`, 8, egress port width; must be ≤ 16.
- `MAX_INSTS`, 16, maximum primitives per list, terminating NOP included.

Ports:
- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  level request; sampled in IDLE only.
- `start_addr_i`  in  ADDR_W  word-aligned byte address of the first primitive.
- `pkt_base_i`  in  ADDR_W  word-aligned byte address of packet byte 0; sampled with `start_i`.
- `sram_ce_o`  out  1  SRAM enable.
- `sram_we_o`  out  1  write strobe.
- `sram_addr_o`  out  ADDR_W  word-aligned byte address.
- `sram_sel_o`  out  4  byte lanes; bit i selects data[8i+7:8i].
- `sram_data_o`  out  32  write data.
- `sram_data_i`  in  32  read data, valid in the cycle after the address is presented.
- `busy_o`  out  1  high from leaving IDLE until return to IDLE.
- `exec_done_o`  out  1  high in DONE.
- `exec_err_o`  out  1  meaningful while `exec_done_o` is high: 1 = unknown opcode or MAX_INSTS exceeded.
- `egress_port_o`  out  PORT_W  last SET_PORT value.
- `port_valid_o`  out  1  a SET_PORT executed in this run.

## Operation
Primitive format:
- Word at address A is inst[63:32]; word at A+4 is inst[31:0].
- Opcode is inst[63:58]: 0 NOP, 2 ADD, 3 COPY_FIELD, 4 SET_FIELD, 5 SET_PORT. Any other opcode is an error.
- dst_off = inst[47:32]; src_off = inst[31:16]; imm = inst[15:0]. Offsets are packet byte offsets.

Field addressing:
- A field is a 16-bit halfword. Offset bit 0 is ignored.
- Word address = pkt_base + {off[15:2],2'b00}.
- off[1]=0 selects lanes 4'b0011, data[15:0]; off[1]=1 selects 4'b1100, data[31:16].
- Unselected lanes of `sram_data_o` are 0.

Primitives:
- SET_FIELD: dst ← imm.
- ADD: dst ← (dst + imm) mod 2^16, no saturation.
- COPY_FIELD: dst ← src.
- SET_PORT: `egress_port_o` ← imm[PORT_W-1:0]; `port_valid_o` ← 1.
- NOP: ends the list, `exec_err_o`=0.

State machine (SRAM outputs registered; an address presented in state S returns data in S+1):
- IDLE: on `start_i`=1, latch `pkt_base_i`, drive start address with ce=1, pc ← start+8, count ← 0, clear `port_valid_o` → F1.
- F1: address ← address+4 → F2.
- F2: inst_hi ← data → F3.
- F3: inst_lo ← data, count ← count+1 → EX.
- EX:
  - NOP or unknown opcode → DONE.
  - SET_PORT: latch the port, then next-fetch.
  - SET_FIELD: drive write (we=1) → WR.
  - ADD: drive read of dst word → R1.
  - COPY_FIELD: drive read of src word → R1.
- R1 → R2.
- R2: ADD computes on the dst lane; COPY extracts the src lane and repositions it to the dst lane. Drive write → WR.
- WR: we ← 0, then next-fetch.
- Next-fetch: address ← pc, pc ← pc+8 → F1. If count = MAX_INSTS, go to DONE with error instead.
- DONE: ce=0, we=0, `exec_done_o`=1. Stay until `start_i`=0 → IDLE, clearing `exec_done_o` and `exec_err_o`.

Boundary conditions:
- `start_i` is ignored while busy.
- COPY with src = dst is a legal rewrite of the same value.
- 16-bit offsets wrap only through ADDR_W addition, with no clipping.

## Timing
- Reset values: all outputs 0; state IDLE; pc, count and instruction registers 0.
- Reset asserted mid-run aborts immediately; no write completes after reset asserts.
- Cycles per primitive, F1 to next F1: SET_PORT 4, SET_FIELD 5, ADD 7, COPY 7.
- A list consisting only of NOP: `exec_done_o` is high in the 5th cycle after the start edge.
- SRAM write occurs exactly in the cycle `sram_we_o`=1 (one cycle per write).

## Structure
- Opcodes, state encodings and lane masks go in `def.v`, alongside `ADDR_BUS`/`DATA_BUS`.
- One combinational sub-module, `hw_lane`: takes word, offset bit 1 and a halfword. It extracts the halfword and builds the write word plus sel for either lane.
- The FSM stays in `prim_executor`.

## Test plan
- SET_FIELD dst=0x000C imm=0x0800, then NOP, with pkt_base=0x1000 → a single write at 0x100C with sel 0011 and data 0x00000800; done with err=0.
- ADD dst=0x000E imm=0x0001 over a word of 0xFFFF1234 → write 0x00000000 with sel 1100; the wrap is correct.
- COPY src=0x0002 dst=0x0004, where word 0x1000 = 0xABCD0000 → write 0x0000ABCD at 0x1004 with sel 0011.
- SET_PORT imm=0x0107 (PORT_W=8), then opcode 0x3F → `egress_port_o`=0x07, `port_valid_o`=1, done with err=1, and no SRAM write.
- 16 SET_PORT primitives with no NOP, MAX_INSTS=16 → err=1 after the 16th primitive; no 17th fetch occurs.
- `rst` pulsed low in R2 of an ADD → all outputs 0 immediately and no write; a new start runs normally, and `start_i` held high in DONE keeps `exec_done_o` asserted.
